// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Memory-port bundle between the multi-cycle control FSM and the unified
// memory port.
//
// Signals:
//   mem_req    controller -> memory  access request
//   mem_we     controller -> memory  write strobe, qualified by mem_req
//   addr_sel   controller -> memory  address mux select (0 = PC, 1 = ALUOut)
//   mem_ready  memory -> controller  access completes in this cycle
//
// Handshake: mem_req is a request/ready pair. Once the controller raises
// mem_req it keeps mem_req, mem_we and addr_sel unchanged on every cycle
// until a cycle in which mem_ready=1; that cycle completes the access. A
// cycle with mem_req=1 and mem_ready=0 is a wait cycle. mem_ready carries
// no meaning while mem_req=0.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multi-cycle RV32I datapath (one ALU, one unified memory
// port, IR / old_pc / ALUOut holding registers). Each cycle it drives the
// datapath selects and enables and counts retired instructions. An illegal
// opcode parks the FSM in TRAP until reset.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset (0 = reset/hold, 1 = run)
//   opcode     IR[6:0], valid from DECODE onward
//   br_taken   ALU branch compare result, valid in BRANCH
//   mem        memory port bundle (master side: mem_req/mem_we/addr_sel out,
//              mem_ready in)
//   ir_write   load IR and old_pc
//   pc_write   load PC
//   pc_src     0 = PC+4, 1 = old_pc+(imm<<1), 2 = ALU result
//   alu_src_a  0 = rs1, 1 = old_pc
//   alu_src_b  0 = rs2, 1 = imm
//   alu_op     00 = add, 01 = sub/compare, 10 = funct-decoded
//   reg_write  register-file write enable
//   wb_sel     0 = ALUOut, 1 = memory data, 2 = old_pc+4
//   state      current state encoding (debug)
//   halted     FSM is in TRAP
//   instret    retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 br_taken,
    multicycle_ctrl_if.master    mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic                 alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic [3:0]           state,
    output logic                 halted,
    output logic [CNT_W-1:0]     instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd15
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_OLDIMM = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] instret_q;
    logic             retire;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;

    // ------------------------------------------------------------------
    // State and counter registers; reset overrides every transition and
    // discards any pending retirement.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore/Mealy outputs. mem_ready only matters in the
    // three memory-access states; wait cycles keep the request lines
    // steady and never retire.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        halted    = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_PLUS4;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_op = ALU_ADD;
                case (opcode)
                    OP_R:             state_d = S_EXEC_R;
                    OP_I:             state_d = S_EXEC_I;
                    OP_LOAD, OP_STOR: state_d = S_MEM_ADDR;
                    OP_BR:            state_d = S_BRANCH;
                    OP_JAL, OP_JALR:  state_d = S_JUMP;
                    default:          state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_op    = ALU_FUNC;
                alu_src_b = 1'b0;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_op    = ALU_FUNC;
                alu_src_b = 1'b1;
                state_d   = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_op    = ALU_ADD;
                alu_src_b = 1'b1;
                state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem.mem_ready) begin
                    state_d = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                wb_sel    = WB_ALU;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = WB_MEM;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_op    = ALU_SUB;
                alu_src_b = 1'b0;
                pc_write  = br_taken;
                pc_src    = PC_OLDIMM;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                reg_write = 1'b1;
                wb_sel    = WB_LINK;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
                // JALR target comes from rs1+imm through the ALU; JAL uses
                // the dedicated old_pc+imm adder.
                if (opcode == OP_JALR) begin
                    pc_src    = PC_ALU;
                    alu_op    = ALU_ADD;
                    alu_src_b = 1'b1;
                end else begin
                    pc_src = PC_OLDIMM;
                end
            end
            S_TRAP: begin
                halted  = 1'b1;
                state_d = S_TRAP;
            end
            default: begin
                // Unused encodings are treated as corruption and halt.
                state_d = S_TRAP;
            end
        endcase
    end

    assign mem.mem_req  = mem_req;
    assign mem.mem_we   = mem_we;
    assign mem.addr_sel = addr_sel;
    assign state        = state_q;
    assign instret      = instret_q;

endmodule
